jt12_op_sched: RTL and testbench

- Slot scheduler and connection controller for the FM operator datapath.
- Runs the 24-slot time-multiplexed sequence (6 channels × 4 operators, entry order S1,S3,S2,S4) and emits the slot-entry strobes and `zero` marker.
- Decodes each channel's algorithm into the operator's modulation-source selects and carrier mask; supplies stage-II-aligned feedback.
- Holds the per-channel algorithm/feedback register file written by the register interface.

---
 rtl/jt12_op_sched.sv | 147 ++++++++++++++
 tb/tb_jt12_op_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jt12_op_sched.sv
// jt12_op_sched: 24-slot FM operator scheduler, algorithm decoder and per-channel alg/fb register file.
// Optional JT12_SLOT_MUTE_EN adds slot_mute[23:0] to force carrier low per slot.
module jt12_op_sched #(
  parameter int NUM_CH    = 6,
  parameter int ZERO_SLOT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_ch,
  input  logic [2:0]  cfg_alg,
  input  logic [2:0]  cfg_fb,
`ifdef JT12_SLOT_MUTE_EN
  input  logic [23:0] slot_mute,
`endif
  output logic [4:0]  slot,
  output logic [2:0]  ch,
  output logic        s1_enters,
  output logic        s2_enters,
  output logic        s3_enters,
  output logic        s4_enters,
  output logic        zero,
  output logic        use_prevprev1,
  output logic        use_internal_x,
  output logic        use_internal_y,
  output logic        use_prev2,
  output logic        use_prev1,
  output logic [2:0]  fb_II,
  output logic        carrier
);
  localparam logic [4:0] ZS = 5'(ZERO_SLOT);
  generate
    if (NUM_CH != 6) begin : g_bad_num_ch
      $error("jt12_op_sched supports NUM_CH=6 only");
    end
  endgenerate
  typedef enum logic [1:0] {G_S1, G_S3, G_S2, G_S4} grp_t;
  grp_t       grp_d;
  logic [4:0] slot_q, slot_d;
  logic [2:0] ch_q, ch_d;
  logic [2:0] cfg_alg_q [6], cfg_alg_d [6], cfg_fb_q [6], cfg_fb_d [6];
  logic [2:0] sh_alg_q [6], sh_alg_d [6], sh_fb_q [6], sh_fb_d [6];
  logic       s1_enters_q, s1_enters_d, s2_enters_q, s2_enters_d;
  logic       s3_enters_q, s3_enters_d, s4_enters_q, s4_enters_d;
  logic       zero_q, zero_d;
  logic       use_prevprev1_q, use_prevprev1_d, use_internal_x_q, use_internal_x_d;
  logic       use_internal_y_q, use_internal_y_d, use_prev2_q, use_prev2_d;
  logic       use_prev1_q, use_prev1_d, carrier_q, carrier_d;
  logic [2:0] fb_ii_q, fb_ii_d;
  logic [2:0] alg;
  logic       car_raw;
  always_comb begin
    slot_d = (slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;
    ch_d   = (ch_q == 3'd5) ? 3'd0 : ch_q + 3'd1;
    grp_d  = slot_d < 5'd6 ? G_S1 : slot_d < 5'd12 ? G_S3 : slot_d < 5'd18 ? G_S2 : G_S4;
    cfg_alg_d = cfg_alg_q;
    cfg_fb_d  = cfg_fb_q;
    if (cfg_we && cfg_ch < 3'd6) begin
      cfg_alg_d[cfg_ch] = cfg_alg;
      cfg_fb_d[cfg_ch]  = cfg_fb;
    end
    // copy on S1 entry reads the post-write RAM so a same-cycle write lands in the shadow
    sh_alg_d = sh_alg_q;
    sh_fb_d  = sh_fb_q;
    if (grp_d == G_S1) begin
      sh_alg_d[ch_d] = cfg_alg_d[ch_d];
      sh_fb_d[ch_d]  = cfg_fb_d[ch_d];
    end
    alg         = sh_alg_d[ch_d];
    s1_enters_d = grp_d == G_S1;
    s2_enters_d = grp_d == G_S2;
    s3_enters_d = grp_d == G_S3;
    s4_enters_d = grp_d == G_S4;
    zero_d      = slot_d == ZS;
    fb_ii_d     = s1_enters_q ? sh_fb_q[ch_q] : fb_ii_q;
    use_prevprev1_d  = s1_enters_d | (s3_enters_d & alg == 3'd5);
    use_internal_x_d = 1'b0;
    use_internal_y_d = s4_enters_d & alg <= 3'd3;
    use_prev2_d      = (s3_enters_d & alg <= 3'd2) | (s2_enters_d & alg == 3'd1)
                     | (s4_enters_d & (alg == 3'd2 || alg == 3'd3));
    use_prev1_d      = s1_enters_d | (s2_enters_d & alg != 3'd2 & alg != 3'd7)
                     | (s4_enters_d & alg == 3'd5);
    car_raw          = s4_enters_d | (s2_enters_d & alg >= 3'd4) | (s3_enters_d & alg >= 3'd5)
                     | (s1_enters_d & alg == 3'd7);
`ifdef JT12_SLOT_MUTE_EN
    carrier_d = car_raw & ~slot_mute[slot_d];
`else
    carrier_d = car_raw;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q           <= '0;
      ch_q             <= '0;
      cfg_alg_q        <= '{default: '0};
      cfg_fb_q         <= '{default: '0};
      sh_alg_q         <= '{default: '0};
      sh_fb_q          <= '{default: '0};
      s1_enters_q      <= 1'b1;
      s2_enters_q      <= 1'b0;
      s3_enters_q      <= 1'b0;
      s4_enters_q      <= 1'b0;
      zero_q           <= ZS == 5'd0;
      fb_ii_q          <= '0;
      use_prevprev1_q  <= 1'b1;
      use_internal_x_q <= 1'b0;
      use_internal_y_q <= 1'b0;
      use_prev2_q      <= 1'b0;
      use_prev1_q      <= 1'b1;
      carrier_q        <= 1'b0;
    end else if (cen) begin
      slot_q           <= slot_d;
      ch_q             <= ch_d;
      cfg_alg_q        <= cfg_alg_d;
      cfg_fb_q         <= cfg_fb_d;
      sh_alg_q         <= sh_alg_d;
      sh_fb_q          <= sh_fb_d;
      s1_enters_q      <= s1_enters_d;
      s2_enters_q      <= s2_enters_d;
      s3_enters_q      <= s3_enters_d;
      s4_enters_q      <= s4_enters_d;
      zero_q           <= zero_d;
      fb_ii_q          <= fb_ii_d;
      use_prevprev1_q  <= use_prevprev1_d;
      use_internal_x_q <= use_internal_x_d;
      use_internal_y_q <= use_internal_y_d;
      use_prev2_q      <= use_prev2_d;
      use_prev1_q      <= use_prev1_d;
      carrier_q        <= carrier_d;
    end
  end
  assign slot           = slot_q;
  assign ch             = ch_q;
  assign s1_enters      = s1_enters_q;
  assign s2_enters      = s2_enters_q;
  assign s3_enters      = s3_enters_q;
  assign s4_enters      = s4_enters_q;
  assign zero           = zero_q;
  assign fb_II          = fb_ii_q;
  assign use_prevprev1  = use_prevprev1_q;
  assign use_internal_x = use_internal_x_q;
  assign use_internal_y = use_internal_y_q;
  assign use_prev2      = use_prev2_q;
  assign use_prev1      = use_prev1_q;
  assign carrier        = carrier_q;
endmodule

// File: tb/tb_jt12_op_sched.sv
// tb_jt12_op_sched: decode table, directed frame sequences and randomized run against a slot-level model.
module tb_jt12_op_sched;
  localparam int ZS = 0;
  logic clk = 0, rst_n = 0, cen = 0, cfg_we = 0;
  logic [2:0] cfg_ch = 0, cfg_alg = 0, cfg_fb = 0;
`ifdef JT12_SLOT_MUTE_EN
  logic [23:0] slot_mute = '0;
`endif
  logic [4:0] slot;
  logic [2:0] ch, fb_II;
  logic s1_enters, s2_enters, s3_enters, s4_enters, zero, carrier;
  logic use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;
  jt12_op_sched #(.NUM_CH(6), .ZERO_SLOT(ZS)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_alg(cfg_alg), .cfg_fb(cfg_fb),
`ifdef JT12_SLOT_MUTE_EN
    .slot_mute(slot_mute),
`endif
    .slot(slot), .ch(ch), .s1_enters(s1_enters), .s2_enters(s2_enters),
    .s3_enters(s3_enters), .s4_enters(s4_enters), .zero(zero),
    .use_prevprev1(use_prevprev1), .use_internal_x(use_internal_x),
    .use_internal_y(use_internal_y), .use_prev2(use_prev2), .use_prev1(use_prev1),
    .fb_II(fb_II), .carrier(carrier)
  );
  always #5 clk = ~clk;
  logic [21:0] obs;
  logic [4:0]  sel_obs;
  assign sel_obs = {use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1};
  assign obs = {slot, ch, s1_enters, s2_enters, s3_enters, s4_enters, zero, sel_obs, fb_II, carrier};
  // sel packs S1,S2,S3,S4 selects {prevprev1,internal_x,internal_y,prev2,prev1}; car is {S1,S2,S3,S4}
  typedef struct packed {
    logic [2:0]  alg;
    logic [19:0] sel;
    logic [3:0]  car;
  } dec_t;
  dec_t tbl [8];
  int ntot = 0, npass = 0;
  int m_slot = 0;
  logic [2:0] m_cfg_alg [6], m_cfg_fb [6], m_sh_alg [6], m_sh_fb [6], m_fb_ii;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (model slot %0d)", n, got, exp, m_slot);
  endtask
  function automatic int op_of(input int s);
    int g = s / 6;
    return g == 0 ? 0 : g == 1 ? 2 : g == 2 ? 1 : 3;
  endfunction
  function automatic logic [21:0] model_out();
    int op = op_of(m_slot);
    int c = m_slot % 6;
    logic [2:0] a = m_sh_alg[c];
    logic [4:0] sel = 5'(tbl[a].sel >> (5 * (3 - op)));
    logic car = tbl[a].car[3 - op];
`ifdef JT12_SLOT_MUTE_EN
    car = car & ~slot_mute[m_slot];
`endif
    return {5'(m_slot), 3'(c), op == 0, op == 1, op == 2, op == 3, m_slot == ZS, sel, m_fb_ii, car};
  endfunction
  task automatic tick(input logic r, input logic c, input logic w,
                      input logic [2:0] wc, input logic [2:0] wa, input logic [2:0] wf);
    rst_n = r; cen = c; cfg_we = w; cfg_ch = wc; cfg_alg = wa; cfg_fb = wf;
    @(posedge clk);
    if (!r) begin
      m_slot = 0;
      m_fb_ii = 0;
      for (int i = 0; i < 6; i++) begin
        m_cfg_alg[i] = 0; m_cfg_fb[i] = 0; m_sh_alg[i] = 0; m_sh_fb[i] = 0;
      end
    end else if (c) begin
      int ps = m_slot;
      m_slot = (m_slot + 1) % 24;
      if (w && wc < 6) begin
        m_cfg_alg[wc] = wa;
        m_cfg_fb[wc] = wf;
      end
      if (ps < 6) m_fb_ii = m_sh_fb[ps];
      if (m_slot < 6) begin
        m_sh_alg[m_slot] = m_cfg_alg[m_slot];
        m_sh_fb[m_slot] = m_cfg_fb[m_slot];
      end
    end
    #1 chk("state", 32'(obs), 32'(model_out()));
  endtask
  task automatic idle();
    tick(1, 1, 0, 0, 0, 0);
  endtask
  task automatic run_to(input int t);
    int k = 0;
    while (m_slot != t && k < 48) begin
      idle();
      k++;
    end
    chk("run_to", 32'(slot), 32'(t));
  endtask
  initial begin
    int zcnt, serr;
    logic [21:0] hold;
    tbl[0] = '{3'd0, {5'b10001, 5'b00001, 5'b00010, 5'b00100}, 4'b0001};
    tbl[1] = '{3'd1, {5'b10001, 5'b00011, 5'b00010, 5'b00100}, 4'b0001};
    tbl[2] = '{3'd2, {5'b10001, 5'b00000, 5'b00010, 5'b00110}, 4'b0001};
    tbl[3] = '{3'd3, {5'b10001, 5'b00001, 5'b00000, 5'b00110}, 4'b0001};
    tbl[4] = '{3'd4, {5'b10001, 5'b00001, 5'b00000, 5'b00000}, 4'b0101};
    tbl[5] = '{3'd5, {5'b10001, 5'b00001, 5'b10000, 5'b00001}, 4'b0111};
    tbl[6] = '{3'd6, {5'b10001, 5'b00001, 5'b00000, 5'b00000}, 4'b0111};
    tbl[7] = '{3'd7, {5'b10001, 5'b00000, 5'b00000, 5'b00000}, 4'b1111};
    tick(0, 0, 0, 0, 0, 0);
    chk("rst_slot", 32'(slot), 0);
    chk("rst_strobes", 32'({s1_enters, s2_enters, s3_enters, s4_enters}), 32'h8);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_sel", 32'(sel_obs), 32'h11);
    chk("rst_car_fb", 32'({carrier, fb_II}), 0);
    zcnt = 0; serr = 0;
    for (int k = 1; k <= 48; k++) begin
      idle();
      zcnt += int'(zero);
      if (slot != 5'(k % 24)) serr++;
    end
    chk("zero_count", 32'(zcnt), 2);
    chk("slot_seq_errs", 32'(serr), 0);
    tick(1, 1, 1, 2, 7, 5);
    for (int k = 0; k < 24; k++) begin
      idle();
      if (m_slot % 6 == 2) chk("ch2_alg7_car", 32'(carrier), 1);
      if (m_slot == 3) chk("ch2_fb_II", 32'(fb_II), 5);
    end
    run_to(18);
    chk("ch0_s4_alg0", 32'({use_internal_y, use_prev2}), 32'b10);
    run_to(19);
    tick(1, 1, 1, 0, 2, 0);
    run_to(18);
    chk("ch0_s4_alg2", 32'({use_internal_y, use_prev2}), 32'b11);
    run_to(0);
    tick(1, 1, 1, 1, 5, 0);
    chk("ch1_s1_car", 32'(carrier), 0);
    run_to(7);
    chk("ch1_s3_pp1_car", 32'({use_prevprev1, carrier}), 32'b11);
    run_to(13);
    chk("ch1_s2_p1_car", 32'({use_prev1, carrier}), 32'b11);
    run_to(19);
    chk("ch1_s4_car", 32'(carrier), 1);
    run_to(9);
    hold = model_out();
    for (int k = 0; k < 10; k++) begin
      tick(1, 0, 1, 3, 7, 7);
      chk("frozen", 32'(obs), 32'(hold));
    end
    idle();
    chk("resume_slot", 32'(slot), 10);
    run_to(3);
    chk("cen0_write_ignored", 32'(carrier), 0);
`ifdef JT12_SLOT_MUTE_EN
    slot_mute = 24'h000008;
    tick(1, 1, 1, 3, 7, 0);
    run_to(4);
    run_to(3);
    chk("mute_s3", 32'(carrier), 0);
    run_to(9);
    chk("mute_9", 32'(carrier), 1);
    run_to(15);
    chk("mute_15", 32'(carrier), 1);
    run_to(21);
    chk("mute_21", 32'(carrier), 1);
    slot_mute = '0;
`endif
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 1, 0, tbl[i].alg, 3'(i));
      run_to(1);
      run_to(0);
      for (int op = 0; op < 4; op++) begin
        run_to(op == 0 ? 0 : op == 1 ? 12 : op == 2 ? 6 : 18);
        chk($sformatf("dec_sel_a%0d_op%0d", i, op), 32'(sel_obs), 32'(5'(tbl[i].sel >> (5 * (3 - op)))));
        chk($sformatf("dec_car_a%0d_op%0d", i, op), 32'(carrier), 32'(tbl[i].car[3 - op]));
      end
    end
`ifdef JT12_SLOT_MUTE_EN
    slot_mute = 24'($urandom);
`endif
    for (int k = 0; k < 1500; k++)
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
